neuron_accumulate: RTL and testbench
====================================

// Module: neuron_accumulate
//
// PURPOSE
//   Sequential weighted-sum stage of one neuron, sitting directly upstream of the activation
//   (prediction) stage. Accepts N_INPUTS (x, w) pairs over a valid/ready stream, one pair per
//   cycle, starting from a bias value. Presents sum = bias + sum(x_i*w_i) together with the
//   latched activation selector, held until the consumer takes it.
//
// PARAMETERS
//   N_INPUTS  4  number of (x, w) beats per neuron evaluation; legal range >= 1
//   CNT_W     $clog2(N_INPUTS+1)  localparam; width of the beat counter
//
// PORTS
//   clk         in   1         clock; all state updates on rising edge
//   rst         in   1         asynchronous, active-high reset
//   start       in   1         begin an evaluation; sampled only in IDLE, or in DONE when out_ready=1
//   bias        in   real      accumulator initial value; captured on the accepted start
//   act_in      in   act_func  activation selector; captured on the accepted start
//   in_valid    in   1         x/w pair valid
//   in_ready    out  1         block accepts a pair this cycle
//   x           in   real      input operand
//   w           in   real      weight operand
//   out_valid   out  1         sum/activation valid; held until out_ready
//   out_ready   in   1         downstream consumes the result
//   sum         out  real      accumulated weighted sum, driven to the activation stage
//   activation  out  act_func  selector latched at start, driven to the activation stage
//   busy        out  1         high in ACCUM or DONE
//
// BEHAVIOUR
//   Reset (async, immediate):
//     state=IDLE; acc=0.0; cnt=0; out_valid=0; in_ready=0; busy=0; sum=0.0; activation=act_func'(0)
//   States:
//     IDLE  : in_ready=0, out_valid=0.
//             start=1 -> acc<=bias, activation<=act_in, cnt<=0, go ACCUM.
//     ACCUM : in_ready=1.
//             On in_valid&&in_ready: acc<=acc+x*w, cnt<=cnt+1.
//             On the beat with cnt==N_INPUTS-1 -> go DONE.
//             in_valid=0 stalls with no state change. start is ignored.
//     DONE  : out_valid=1, sum=acc (registered, stable while out_valid=1), in_ready=0.
//             out_ready=0 -> hold all outputs unchanged.
//             out_ready=1, start=0 -> go IDLE.
//             out_ready=1, start=1 -> reload bias/act_in, cnt<=0, go ACCUM (back-to-back, no IDLE bubble).
//   Timing:
//     - start accepted at cycle T.
//     - Beats accepted no earlier than T+1.
//     - out_valid rises the cycle after the last beat is accepted.
//     - Minimum start-to-out_valid latency is N_INPUTS+1 cycles.
//   Arithmetic:
//     - real (IEEE double) multiply-add, one product per beat, accumulated in arrival order.
//     - No saturation or rounding beyond the native real semantics.
//   sum is driven from acc only through the DONE register path.
//     - It holds its last value in IDLE/ACCUM; out_valid qualifies it.
//   Boundaries:
//     - N_INPUTS=1: the single beat moves ACCUM->DONE directly.
//     - cnt never exceeds N_INPUTS-1; extra in_valid after the final beat sees in_ready=0 and is
//       not consumed.
//     - start while in ACCUM, or in DONE without out_ready: ignored, no effect on acc or activation.
//     - rst asserted mid-ACCUM or in DONE: the partial result is discarded; out_valid drops
//       immediately (async) and no stale result is emitted after release.
//     - act_in/bias changes after the accepted start do not affect the current evaluation.
//
// TESTING
//   1. N_INPUTS=4, bias=0.5, x={1,2,3,4}, w={0.5,0.5,0.5,0.5}, in_valid held high
//      -> out_valid 5 cycles after start, sum=5.5.
//   2. Same data with in_valid gap cycles between beats
//      -> identical sum=5.5; out_valid delayed by the gap count; no beat lost or duplicated.
//   3. DONE with out_ready=0 for 3 cycles
//      -> sum/activation/out_valid stable; then out_ready=1 -> IDLE next cycle, out_valid=0.
//   4. DONE with out_ready=1 and start=1, bias=-1.0, x=w={1,1,1,1}
//      -> second out_valid with sum=3.0, activation=new act_in, no IDLE cycle between.
//   5. rst pulsed after 2 of 4 beats
//      -> out_valid=0, in_ready=0 immediately; new start yields a correct sum unaffected by the
//         aborted partial.
//   6. start pulsed during ACCUM with a different bias/act_in
//      -> ignored; result equals the original bias-based sum and activation.

Source files
------------

// File: rtl/neuron_accumulate.sv
// Sequential weighted-sum stage of one neuron: bias + sum(x_i*w_i) over N_INPUTS
// valid/ready beats, result held with its activation selector until consumed.
package neuron_pkg;
    typedef enum logic [1:0] {
        ACT_LINEAR  = 2'd0,
        ACT_RELU    = 2'd1,
        ACT_SIGMOID = 2'd2,
        ACT_TANH    = 2'd3
    } act_func;
endpackage

// Input stream: a pair moves when in_valid && in_ready at a rising edge.
// Output stream: the result moves when out_valid && out_ready at a rising edge;
// sum/activation stay stable while out_valid is high and out_ready is low.
module neuron_accumulate
    import neuron_pkg::*;
#(
    parameter int N_INPUTS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  real        bias,
    input  act_func    act_in,
    input  logic       in_valid,
    output logic       in_ready,
    input  real        x,
    input  real        w,
    output logic       out_valid,
    input  logic       out_ready,
    output real        sum,
    output act_func    activation,
    output logic       busy,
    output logic [1:0] state_dbg
);
    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    real              r_acc;
    real              r_sum;
    logic [CNT_W-1:0] r_cnt;
    act_func          r_act;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    real              w_next_acc;

    assign w_next_acc = r_acc + x * w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= 0.0;
            r_sum       <= 0.0;
            r_cnt       <= '0;
            r_act       <= act_func'(0);
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc      <= bias;
                        r_act      <= act_in;
                        r_cnt      <= '0;
                        r_state    <= S_ACCUM;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        r_acc <= w_next_acc;
                        // The final beat lands straight in the output register.
                        if (r_cnt == LAST_BEAT) begin
                            r_cnt       <= '0;
                            r_sum       <= w_next_acc;
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (start) begin
                            r_acc      <= bias;
                            r_act      <= act_in;
                            r_cnt      <= '0;
                            r_state    <= S_ACCUM;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign sum        = r_sum;
    assign activation = r_act;
    assign busy       = r_busy;
    assign state_dbg  = r_state;
endmodule

// File: tb/tb_neuron_accumulate.sv
// Bench for neuron_accumulate: directed scenarios with literal sums plus a long
// randomized run, all checked every cycle against a transaction-level model.
module tb_neuron_accumulate;
    import neuron_pkg::*;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    real        bias = 0.0;
    act_func    act_in = ACT_LINEAR;
    logic       in_valid = 1'b0;
    logic       in_ready;
    real        x = 0.0;
    real        w = 0.0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    real        sum;
    act_func    activation;
    logic       busy;
    logic [1:0] state_dbg;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    neuron_accumulate #(.N_INPUTS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .bias(bias), .act_in(act_in),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .w(w),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .activation(activation), .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_real(input string name, input real act, input real exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %g expected %g at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_act(input string name, input act_func act, input act_func exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an evaluation is open while fewer than N beats
    // have been taken; a finished result is pending until the consumer takes it.
    bit      m_open = 1'b0;
    bit      m_pending = 1'b0;
    int      m_beats = 0;
    real     m_acc = 0.0;
    real     m_result = 0.0;
    act_func m_act = ACT_LINEAR;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_open = 1'b0; m_pending = 1'b0; m_beats = 0;
            m_acc = 0.0; m_result = 0.0; m_act = ACT_LINEAR;
        end else begin
            bit take_start;
            take_start = start && ((!m_open && !m_pending) || (m_pending && out_ready));
            if (m_pending && out_ready) m_pending = 1'b0;
            if (m_open && in_valid) begin
                m_acc = m_acc + x * w;
                m_beats++;
                if (m_beats == N) begin
                    m_open = 1'b0; m_pending = 1'b1; m_result = m_acc;
                end
            end else if (take_start) begin
                m_open = 1'b1; m_beats = 0; m_acc = bias; m_act = act_in;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk_bit("out_valid", out_valid, m_pending);
            chk_bit("in_ready", in_ready, m_open);
            chk_bit("busy", busy, m_open || m_pending);
            chk_real("sum", sum, m_result);
            chk_act("activation", activation, m_act);
        end
    end

    // Starts an evaluation, feeds four beats with gaps[i] idle cycles before
    // beat i, and returns the cycle (start cycle = 0) where out_valid was seen.
    task automatic run_eval(input real b, input act_func a, input real xs[4],
                            input real ws[4], input int gaps[4], input bit stray,
                            output int lat);
        int cyc;
        @(negedge clk);
        start = 1'b1; bias = b; act_in = a; in_valid = 1'b0; out_ready = 1'b0;
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                @(negedge clk); cyc++;
                start = stray; bias = 99.0; act_in = ACT_SIGMOID;
                in_valid = 1'b0; x = 7.0; w = 7.0;
            end
            @(negedge clk); cyc++;
            start = stray; bias = 99.0; act_in = ACT_SIGMOID;
            in_valid = 1'b1; x = xs[i]; w = ws[i];
        end
        @(negedge clk); cyc++;
        start = 1'b0; in_valid = 1'b0;
        lat = out_valid ? cyc : -1;
    endtask

    task automatic release_result();
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        chk_bit("released_out_valid", out_valid, 1'b0);
        chk_bit("released_busy", busy, 1'b0);
    endtask

    initial begin
        real xs_a[4] = '{1.0, 2.0, 3.0, 4.0};
        real ws_a[4] = '{0.5, 0.5, 0.5, 0.5};
        real ones[4] = '{1.0, 1.0, 1.0, 1.0};
        real qrt[4]  = '{0.25, 0.25, 0.25, 0.25};
        int  no_gap[4] = '{0, 0, 0, 0};
        int  gaps[4]   = '{0, 2, 1, 0};
        int  lat;

        #1;
        chk_bit("reset_out_valid", out_valid, 1'b0);
        chk_bit("reset_in_ready", in_ready, 1'b0);
        chk_bit("reset_busy", busy, 1'b0);
        chk_real("reset_sum", sum, 0.0);
        chk_act("reset_activation", activation, ACT_LINEAR);
        #12 rst = 1'b0;
        chk_en = 1'b1;

        // Back-to-back beats: extra in_valid after the last beat must be refused.
        @(negedge clk);
        start = 1'b1; bias = 0.5; act_in = ACT_RELU; in_valid = 1'b1; x = 1.0; w = 0.5;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0; x = real'(i); w = 0.5;
            if (i == 4) chk_bit("t1_not_yet_valid", out_valid, 1'b0);
        end
        @(negedge clk); x = 9.0;
        chk_bit("t1_valid_at_5", out_valid, 1'b1);
        chk_real("t1_sum", sum, 5.5);
        chk_act("t1_act", activation, ACT_RELU);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); in_valid = 1'b0;
            chk_bit("t3_hold_valid", out_valid, 1'b1);
            chk_real("t3_hold_sum", sum, 5.5);
        end
        release_result();

        run_eval(0.5, ACT_SIGMOID, xs_a, ws_a, gaps, 1'b0, lat);
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL t2_latency: got %0d expected 8", lat);
        end
        chk_real("t2_sum", sum, 5.5);

        // Consume and restart in the same cycle.
        @(negedge clk);
        out_ready = 1'b1; start = 1'b1; bias = -1.0; act_in = ACT_TANH;
        @(negedge clk);
        out_ready = 1'b0; start = 1'b0; in_valid = 1'b1; x = 1.0; w = 1.0;
        chk_bit("t4_no_bubble_ready", in_ready, 1'b1);
        chk_bit("t4_no_bubble_busy", busy, 1'b1);
        chk_bit("t4_valid_dropped", out_valid, 1'b0);
        repeat (3) @(negedge clk);
        @(negedge clk); in_valid = 1'b0;
        chk_bit("t4_valid", out_valid, 1'b1);
        chk_real("t4_sum", sum, 3.0);
        chk_act("t4_act", activation, ACT_TANH);
        release_result();

        // Abort after two beats.
        @(negedge clk); start = 1'b1; bias = 0.5; act_in = ACT_RELU;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; x = 1.0; w = 0.5;
        @(negedge clk); x = 2.0;
        @(negedge clk); in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_bit("t5_rst_out_valid", out_valid, 1'b0);
        chk_bit("t5_rst_in_ready", in_ready, 1'b0);
        chk_bit("t5_rst_busy", busy, 1'b0);
        #1 rst = 1'b0;
        run_eval(2.0, ACT_LINEAR, ones, qrt, no_gap, 1'b0, lat);
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL t5_latency: got %0d expected 5", lat);
        end
        chk_real("t5_sum", sum, 3.0);
        release_result();

        // Stray starts during accumulation must change nothing.
        run_eval(0.5, ACT_RELU, xs_a, ws_a, gaps, 1'b1, lat);
        chk_real("t6_sum", sum, 5.5);
        chk_act("t6_act", activation, ACT_RELU);
        release_result();

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start     = ($urandom_range(0, 3) == 0);
            bias      = real'($urandom_range(0, 32)) / 8.0 - 2.0;
            act_in    = act_func'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 3) != 0);
            x         = real'($urandom_range(0, 32)) / 8.0 - 2.0;
            w         = real'($urandom_range(0, 32)) / 4.0 - 4.0;
            out_ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
